branch_checkpoint_queue: RTL and testbench

Parametrised in-order queue of in-flight branch checkpoints between decode/rename and the branch execution unit. Allocates a tag per dispatched branch or jump and requests a RAT checkpoint copy. On resolution it either retires the checkpoint in order or, on mispredict, requests a RAT restore and squashes all younger checkpoints through a kill mask. Resolution is keyed by tag rather than PC, and allocation is back-pressured.

---
 rtl/bcq_pkg.sv | 19 +
 rtl/bcq_age_mask.sv | 25 ++
 rtl/branch_checkpoint_queue.sv | 130 +++++++++++++
 tb/tb_branch_checkpoint_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcq_pkg.sv
// Shared sizing and decode constants for the branch checkpoint queue.
// No logic, so no latency.
// No flow control here; the decode-side opcode helper is purely combinational.
package bcq_pkg;

    localparam int BCQ_DEPTH = 8;
    localparam int BCQ_PC_W  = 32;
    localparam int BCQ_TAG_W = $clog2(BCQ_DEPTH);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Decode uses this to qualify alloc_valid: every control-flow op needs a checkpoint.
    function automatic logic is_ctrl_op(input logic [6:0] opcode);
        return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
    endfunction

endpackage

// File: rtl/bcq_age_mask.sv
// Marks every valid checkpoint strictly younger than a given tag.
// Latency: combinational.
// Backpressure: none.
module bcq_age_mask #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic [TAG_W-1:0] head,
    input  logic [TAG_W-1:0] tag,
    input  logic [DEPTH-1:0] valid,
    output logic [DEPTH-1:0] kill_mask
);

    logic [TAG_W-1:0] tag_age;

    // Ages are distances from head modulo DEPTH, so wrapped entries compare correctly.
    assign tag_age = tag - head;

    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        logic [TAG_W-1:0] ent_age;
        assign ent_age      = TAG_W'(i) - head;
        assign kill_mask[i] = valid[i] && (ent_age > tag_age);
    end

endmodule

// File: rtl/branch_checkpoint_queue.sv
// In-order queue of in-flight branch checkpoints with tag-keyed resolve and mispredict squash.
// Latency: alloc->copy_rat 1, resolve->restore_rat 1, correct head resolve->free_valid 2 cycles.
// Backpressure: alloc_ready low when full (registered count) or an accepted mispredict is present.
module branch_checkpoint_queue
    import bcq_pkg::*;
#(
    parameter int DEPTH = BCQ_DEPTH,
    parameter int PC_W  = BCQ_PC_W,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [PC_W-1:0]   alloc_pc,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    output logic              copy_rat,
    output logic [TAG_W-1:0]  copy_tag,
    input  logic              resolve_valid,
    input  logic [TAG_W-1:0]  resolve_tag,
    input  logic              resolve_mispredict,
    output logic              restore_rat,
    output logic [TAG_W-1:0]  restore_tag,
    output logic [PC_W-1:0]   restore_pc,
    output logic [DEPTH-1:0]  kill_mask,
    output logic              free_valid,
    output logic [TAG_W-1:0]  free_tag,
    output logic [TAG_W:0]    count
);

    logic [PC_W-1:0]  pc_q [DEPTH];
    logic [DEPTH-1:0] valid_q, resolved_q;
    logic [DEPTH-1:0] valid_d, resolved_d;
    logic [TAG_W:0]   head_q, tail_q;
    logic [TAG_W:0]   tail_restore;
    logic [TAG_W-1:0] head_idx, tail_idx, tag_age;
    logic [DEPTH-1:0] age_kill;
    logic             resolve_hit, mispredict, alloc_fire, retire;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign count    = tail_q - head_q;

    assign resolve_hit = resolve_valid && valid_q[resolve_tag];
    assign mispredict  = resolve_hit && resolve_mispredict;
    assign retire      = valid_q[head_idx] && resolved_q[head_idx];

    // count never exceeds DEPTH, so its MSB alone flags full.
    assign alloc_ready = !count[TAG_W] && !mispredict;
    assign alloc_tag   = tail_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // New tail sits just after the mispredicted tag; rebuilding it from head keeps the wrap bit right.
    assign tag_age      = resolve_tag - head_idx;
    assign tail_restore = head_q + {1'b0, tag_age} + (TAG_W+1)'(1);

    bcq_age_mask #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_age_mask (
        .head      (head_idx),
        .tag       (resolve_tag),
        .valid     (valid_q),
        .kill_mask (age_kill)
    );

    always_comb begin
        valid_d    = valid_q;
        resolved_d = resolved_q;
        if (retire) begin
            valid_d[head_idx] = 1'b0;
        end
        if (resolve_hit) begin
            resolved_d[resolve_tag] = 1'b1;
        end
        if (mispredict) begin
            valid_d    = valid_d & ~age_kill;
            resolved_d = resolved_d & ~age_kill;
        end
        if (alloc_fire) begin
            valid_d[tail_idx]    = 1'b1;
            resolved_d[tail_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            valid_q     <= '0;
            resolved_q  <= '0;
            copy_rat    <= 1'b0;
            copy_tag    <= '0;
            restore_rat <= 1'b0;
            restore_tag <= '0;
            restore_pc  <= '0;
            kill_mask   <= '0;
            free_valid  <= 1'b0;
            free_tag    <= '0;
        end else begin
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            head_q     <= head_q + (TAG_W+1)'(retire);
            tail_q     <= mispredict ? tail_restore : tail_q + (TAG_W+1)'(alloc_fire);

            copy_rat    <= alloc_fire;
            restore_rat <= mispredict;
            free_valid  <= retire;
            if (alloc_fire) begin
                copy_tag <= tail_idx;
            end
            if (mispredict) begin
                restore_tag <= resolve_tag;
                restore_pc  <= pc_q[resolve_tag];
                kill_mask   <= age_kill;
            end
            if (retire) begin
                free_tag <= head_idx;
            end
        end
    end

    // PC payload needs no reset: it is only read through a valid entry.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pc_q[tail_idx] <= alloc_pc;
        end
    end

endmodule

// File: tb/tb_branch_checkpoint_queue.sv
// Self-checking bench: fixed vector table, hand-written corner sequences, and random traffic
// compared against an ordered-list model of in-flight checkpoints.
module tb_branch_checkpoint_queue;

    localparam int DEPTH = 8;
    localparam int PC_W  = 32;
    localparam int TAG_W = 3;

    logic             clk;
    logic             rst;
    logic             alloc_valid;
    logic [PC_W-1:0]  alloc_pc;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             copy_rat;
    logic [TAG_W-1:0] copy_tag;
    logic             resolve_valid;
    logic [TAG_W-1:0] resolve_tag;
    logic             resolve_mispredict;
    logic             restore_rat;
    logic [TAG_W-1:0] restore_tag;
    logic [PC_W-1:0]  restore_pc;
    logic [DEPTH-1:0] kill_mask;
    logic             free_valid;
    logic [TAG_W-1:0] free_tag;
    logic [TAG_W:0]   count;

    branch_checkpoint_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .alloc_valid        (alloc_valid),
        .alloc_pc           (alloc_pc),
        .alloc_ready        (alloc_ready),
        .alloc_tag          (alloc_tag),
        .copy_rat           (copy_rat),
        .copy_tag           (copy_tag),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .restore_rat        (restore_rat),
        .restore_tag        (restore_tag),
        .restore_pc         (restore_pc),
        .kill_mask          (kill_mask),
        .free_valid         (free_valid),
        .free_tag           (free_tag),
        .count              (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: program-order list of live checkpoints, oldest first.
    typedef struct {
        int          tag;
        logic [31:0] pc;
        bit          res;
    } ment_t;

    ment_t mq[$];
    int    mhead;

    logic             smp_ready;
    logic [TAG_W-1:0] smp_atag;
    logic [TAG_W:0]   smp_count;

    function automatic int mfind(input int t);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == t) return i;
        end
        return -1;
    endfunction

    // Drive one cycle, check combinational outputs, clock, check registered pulses.
    task automatic step(input bit av, input logic [31:0] apc, input bit rv, input int rtag, input bit rmis);
        int          pos;
        bit          mis, fire, ret, e_ready;
        int          e_atag, ftag;
        logic [7:0]  e_kill;
        logic [31:0] e_rpc;
        ment_t       ne;

        alloc_valid        = av;
        alloc_pc           = apc;
        resolve_valid      = rv;
        resolve_tag        = TAG_W'(rtag);
        resolve_mispredict = rmis;
        #1;
        smp_ready = alloc_ready;
        smp_atag  = alloc_tag;
        smp_count = count;

        pos     = rv ? mfind(rtag) : -1;
        mis     = (pos >= 0) && rmis;
        e_ready = (mq.size() < DEPTH) && !mis;
        e_atag  = (mhead + mq.size()) % DEPTH;
        chk("alloc_ready", alloc_ready, e_ready);
        chk("alloc_tag", alloc_tag, e_atag);
        chk("count", count, mq.size());

        fire   = av && e_ready;
        ret    = (mq.size() > 0) && mq[0].res;
        ftag   = ret ? mq[0].tag : 0;
        e_kill = '0;
        e_rpc  = '0;
        if (pos >= 0) mq[pos].res = 1'b1;
        if (mis) begin
            e_rpc = mq[pos].pc;
            for (int i = pos + 1; i < mq.size(); i++) e_kill[mq[i].tag] = 1'b1;
            while (mq.size() > pos + 1) void'(mq.pop_back());
        end
        if (ret) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % DEPTH;
        end
        if (fire) begin
            ne.tag = e_atag;
            ne.pc  = apc;
            ne.res = 1'b0;
            mq.push_back(ne);
        end

        @(posedge clk);
        #1;
        chk("copy_rat", copy_rat, fire);
        if (fire) chk("copy_tag", copy_tag, e_atag);
        chk("free_valid", free_valid, ret);
        if (ret) chk("free_tag", free_tag, ftag);
        chk("restore_rat", restore_rat, mis);
        if (mis) begin
            chk("restore_tag", restore_tag, rtag);
            chk("restore_pc", restore_pc, e_rpc);
            chk("kill_mask", kill_mask, e_kill);
        end
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        alloc_valid        = 1'b0;
        alloc_pc           = '0;
        resolve_valid      = 1'b0;
        resolve_tag        = '0;
        resolve_mispredict = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        mhead = 0;
        chk("rst_count", count, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_pulses", {copy_rat, restore_rat, free_valid}, 0);
        chk("rst_tags", {copy_tag, restore_tag, free_tag}, 0);
        chk("rst_restore_pc", restore_pc, 0);
        chk("rst_kill_mask", kill_mask, 0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          av;
        logic [31:0] apc;
        bit          rv;
        int          rtag;
        bit          rmis;
        bit          e_ready;
        int          e_atag;
        int          e_count;
        bit          e_copy;
        int          e_ctag;
        bit          e_free;
        int          e_ftag;
        bit          e_rest;
        int          e_rtag;
        logic [31:0] e_rpc;
        logic [7:0]  e_kill;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // av apc rv rtag rmis | ready atag count | copy ctag free ftag rest rtag rpc kill
        tbl[0]  = '{1, 32'h100, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0,   8'h00};
        tbl[1]  = '{1, 32'h104, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 32'h0,   8'h00};
        tbl[2]  = '{1, 32'h108, 0, 0, 0, 1, 2, 2, 1, 2, 0, 0, 0, 0, 32'h0,   8'h00};
        tbl[3]  = '{1, 32'h10c, 0, 0, 0, 1, 3, 3, 1, 3, 0, 0, 0, 0, 32'h0,   8'h00};
        tbl[4]  = '{1, 32'h110, 0, 0, 0, 1, 4, 4, 1, 4, 0, 0, 0, 0, 32'h0,   8'h00};
        tbl[5]  = '{1, 32'h114, 1, 2, 1, 0, 5, 5, 0, 0, 0, 0, 1, 2, 32'h108, 8'h18};
        tbl[6]  = '{0, 32'h0,   0, 0, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 32'h0,   8'h00};
        tbl[7]  = '{0, 32'h0,   1, 1, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 32'h0,   8'h00};
        tbl[8]  = '{0, 32'h0,   1, 0, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 32'h0,   8'h00};
        tbl[9]  = '{0, 32'h0,   0, 0, 0, 1, 3, 3, 0, 0, 1, 0, 0, 0, 32'h0,   8'h00};
        tbl[10] = '{0, 32'h0,   0, 0, 0, 1, 3, 2, 0, 0, 1, 1, 0, 0, 32'h0,   8'h00};
        tbl[11] = '{0, 32'h0,   0, 0, 0, 1, 3, 1, 0, 0, 1, 2, 0, 0, 32'h0,   8'h00};
        tbl[12] = '{0, 32'h0,   1, 5, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0,   8'h00};

        do_reset();
        for (int v = 0; v < 13; v++) begin
            step(tbl[v].av, tbl[v].apc, tbl[v].rv, tbl[v].rtag, tbl[v].rmis);
            chk($sformatf("v%0d_ready", v), smp_ready, tbl[v].e_ready);
            chk($sformatf("v%0d_atag", v), smp_atag, tbl[v].e_atag);
            chk($sformatf("v%0d_count", v), smp_count, tbl[v].e_count);
            chk($sformatf("v%0d_pulses", v), {copy_rat, free_valid, restore_rat},
                {tbl[v].e_copy, tbl[v].e_free, tbl[v].e_rest});
            if (tbl[v].e_copy) chk($sformatf("v%0d_ctag", v), copy_tag, tbl[v].e_ctag);
            if (tbl[v].e_free) chk($sformatf("v%0d_ftag", v), free_tag, tbl[v].e_ftag);
            if (tbl[v].e_rest) begin
                chk($sformatf("v%0d_rtag", v), restore_tag, tbl[v].e_rtag);
                chk($sformatf("v%0d_rpc", v), restore_pc, tbl[v].e_rpc);
                chk($sformatf("v%0d_kill", v), kill_mask, tbl[v].e_kill);
            end
        end

        // Fill to full, then try one more allocation.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 32'h200 + 32'(4 * i), 0, 0, 0);
        step(1, 32'h2ff, 0, 0, 0);
        chk("full_ready", smp_ready, 0);
        chk("full_no_copy", copy_rat, 0);
        chk("full_count", count, 8);

        // Drain tags 0..5 so head sits at 6, then wrap the tail.
        for (int i = 0; i < 6; i++) step(0, 0, 1, i, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("wrap_count", count, 2);
        step(1, 32'h300, 0, 0, 0);
        chk("wrap_alloc0", copy_tag, 0);
        step(1, 32'h304, 0, 0, 0);
        chk("wrap_alloc1", copy_tag, 1);
        step(1, 32'h308, 1, 7, 1);
        chk("wrap_mis_ready", smp_ready, 0);
        chk("wrap_restore_tag", restore_tag, 7);
        chk("wrap_restore_pc", restore_pc, 32'h21c);
        chk("wrap_kill", kill_mask, 8'h03);
        step(0, 0, 0, 0, 0);
        chk("wrap_next_tag", smp_atag, 0);
        chk("wrap_after_count", smp_count, 2);

        // Reset with live entries discards them silently.
        step(0, 0, 1, 6, 0);
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_mid_no_free", free_valid, 0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            bit          av, rv, rmis;
            int          rtag, p;
            logic [31:0] apc;
            av   = ($urandom_range(0, 2) != 0);
            apc  = $urandom & 32'hffff_fffc;
            rv   = ($urandom_range(0, 2) == 0);
            rtag = $urandom_range(0, DEPTH - 1);
            rmis = ($urandom_range(0, 5) == 0);
            p    = mfind(rtag);
            if (p >= 0 && mq[p].res) rv = 1'b0;
            step(av, apc, rv, rtag, rmis);
        end

        alloc_valid   = 1'b0;
        resolve_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
